fetch_ctrl: RTL
===============

# fetch_ctrl

Front-end sequencer for the pipelined CPU: drives the PC register's `npc` and `stall` inputs and the IF/ID and ID/EX pipeline-register controls. It handles a variable-latency instruction-memory handshake, load-use stalls and EX-stage redirects (taken branch or jump). A redirect that arrives while a fetch is still outstanding is held in a drain state until the fetch completes. A free-running counter records front-end bubble cycles for performance monitoring.

## Interface
- `WIDTH`, 32, address/data width
- `RESET_PC`, 32'h00400000, boot address; must equal the PC register's reset value
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous reset, active-high
- `en`  in  1  global enable; low freezes all state
- `pc`  in  WIDTH  current PC from the PC register
- `load_use`  in  1  load-use hazard from the hazard detector (ID/EX)
- `ex_redirect`  in  1  EX resolved a taken branch or jump
- `ex_target`  in  WIDTH  redirect target, valid with `ex_redirect`
- `imem_ready`  in  1  instruction memory has returned the word for `pc`
- `imem_req`  out  1  fetch request for `pc`
- `npc`  out  WIDTH  next PC to the PC register
- `pc_stall`  out  1  holds the PC register
- `if_id_stall`  out  1  holds the IF/ID register
- `if_id_flush`  out  1  loads a bubble into IF/ID
- `id_ex_flush`  out  1  loads a bubble into ID/EX
- `bubble_cnt`  out  32  count of cycles with `pc_stall`=1 (en=1, rst=0)

## Operation
- States:
  - FETCH: `imem_req`=1.
  - DRAIN: redirect is pending and the outstanding fetch is being discarded; `imem_req`=1.
- Registers: `state`, `pend_target[WIDTH]`, `bubble_cnt[32]`.
- Fetch completes in a cycle where `imem_req`=1 and `imem_ready`=1.
- FETCH priority, highest first:
  1. `ex_redirect` and `imem_ready`: `npc`=`ex_target`, `pc_stall`=0, `if_id_flush`=1, `id_ex_flush`=1. Stay in FETCH.
  2. `ex_redirect` and not `imem_ready`: `pend_target`<=`ex_target`, `pc_stall`=1, `if_id_flush`=1, `id_ex_flush`=1. Go to DRAIN.
  3. `load_use`: `pc_stall`=1, `if_id_stall`=1, `id_ex_flush`=1, `if_id_flush`=0, whether or not `imem_ready` is high. The word is re-fetched next cycle.
  4. not `imem_ready`: `pc_stall`=1, `if_id_flush`=1.
  5. Otherwise: `npc`=`pc`+4 (modulo 2^WIDTH; wraps silently), `pc_stall`=0, all other controls 0.
- DRAIN:
  - `pc_stall`=1 and `if_id_flush`=1 every cycle; `load_use` is ignored.
  - On `imem_ready`: `npc`=`pend_target`, `pc_stall`=0, return to FETCH. The returned word is discarded through `if_id_flush`=1.
  - `ex_redirect` in DRAIN overwrites `pend_target`; the newest redirect wins.
- `npc` is `pc`+4 whenever not otherwise specified, so it is never X.
- `en`=0: state, `pend_target` and `bubble_cnt` are held. Outputs are `imem_req`=0, `pc_stall`=1, `if_id_stall`=1, both flushes 0.

## Timing
- All control outputs are combinational from state and inputs; the registers update on the rising `clk` edge.
- Redirect latency:
  - `imem_ready` high in the redirect cycle: `pc`=`ex_target` one cycle later.
  - Otherwise: `pc`=`pend_target` one cycle after the first `imem_ready` seen in DRAIN.
- Reset (`rst`=1, regardless of `en`):
  - Next-state values: `state`=FETCH, `pend_target`=0, `bubble_cnt`=0.
  - Outputs during the reset cycle: `imem_req`=0, `npc`=`RESET_PC`, `pc_stall`=0, `if_id_stall`=0, `if_id_flush`=1, `id_ex_flush`=1.
- Reset asserted in DRAIN aborts the pending redirect; the first post-reset fetch is at `RESET_PC`.
- `bubble_cnt` increments by 1 on each counted cycle and wraps from 2^32-1 to 0.
- Simultaneous `ex_redirect` and `load_use`: the redirect wins, and the load-use bubble is subsumed by `id_ex_flush`.

## Structure
- Shared package `cpu_pkg`:
  - state encoding enum, FETCH=0 and DRAIN=1
  - `RESET_PC` constant, shared with the PC register
  - `INSTR_BYTES`=4
- One sub-module, `perf_counter` (32-bit, enable plus synchronous clear), instantiated for `bubble_cnt`.
- The next-state and output logic is a single combinational block with an explicit priority chain.

## Test plan
- Reset, then `imem_ready`=1 held, no hazards: `pc` runs 0x00400000, 0x00400004, 0x00400008; `bubble_cnt` stays 0.
- `load_use` pulsed for 1 cycle at `pc`=0x00400008: `pc_stall`=1, `if_id_stall`=1 and `id_ex_flush`=1 for exactly 1 cycle; `pc` is held, then advances to 0x0040000C; `bubble_cnt`=1.
- `ex_redirect` with target 0x00400100 and `imem_ready`=1: both flushes high, next `pc`=0x00400100, FSM stays in FETCH.
- `ex_redirect` with target 0x00400200 and `imem_ready`=0 for 3 cycles: FSM enters DRAIN with `if_id_flush` high throughout; after `imem_ready` rises, next `pc`=0x00400200; `bubble_cnt`=4 (3 wait cycles plus the redirect cycle).
- `ex_redirect` and `load_use` in the same cycle, `imem_ready`=1: the redirect is taken, `if_id_stall`=0, next `pc`=target.
- `rst` while in DRAIN with pending 0x00400300: the next fetch address is 0x00400000, and 0x00400300 is never fetched. `en`=0 for 2 cycles mid-stream: all state and `bubble_cnt` are unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: front-end state encoding, boot address and
// instruction size. The PC register imports RESET_PC from here too, so
// the two always agree on the boot address.
package cpu_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  localparam logic [31:0] RESET_PC    = 32'h0040_0000;
  localparam int          INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of signals between the fetch sequencer and the datapath.
// The master modport belongs to fetch_ctrl, which drives the pipeline
// controls. The slave modport belongs to the datapath/PC-register side,
// which supplies the PC, the hazards and the memory handshake.
interface fetch_ctrl_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] pc;
  logic             load_use;
  logic             ex_redirect;
  logic [WIDTH-1:0] ex_target;
  logic             imem_ready;
  logic             imem_req;
  logic [WIDTH-1:0] npc;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic [31:0]      bubble_cnt;

  modport master (
    input  pc, load_use, ex_redirect, ex_target, imem_ready,
    output imem_req, npc, pc_stall, if_id_stall, if_id_flush, id_ex_flush,
           bubble_cnt
  );

  modport slave (
    output pc, load_use, ex_redirect, ex_target, imem_ready,
    input  imem_req, npc, pc_stall, if_id_stall, if_id_flush, id_ex_flush,
           bubble_cnt
  );
endinterface

// File: rtl/perf_counter.sv
// Free-running event counter with a synchronous clear and a count enable.
// When both are asserted, clear wins. The count wraps silently at the
// top of its range.
module perf_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  // Count qualified events; a clear overrides any increment.
  always_ff @(posedge clk) begin
    if (clear_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Front-end sequencer. It produces the next PC and the stall/flush
// controls for the PC, IF/ID and ID/EX registers. It also tracks a
// variable-latency instruction-memory handshake. A redirect that arrives
// while a fetch is still outstanding is parked in DRAIN until that fetch
// returns. The returned word is then flushed, and the PC jumps to the
// parked target.
module fetch_ctrl
  import cpu_pkg::fetch_state_e;
  import cpu_pkg::FETCH;
  import cpu_pkg::DRAIN;
  import cpu_pkg::INSTR_BYTES;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  fetch_ctrl_if.master bus
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;

  logic [WIDTH-1:0] seq_pc;
  logic             imem_req;
  logic [WIDTH-1:0] npc;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             count_bubble;

  assign seq_pc = bus.pc + WIDTH'(INSTR_BYTES);

  // Next-state and control decode. Reset and the global enable sit above
  // the per-state priority chain. npc defaults to the sequential address,
  // so it is never left undefined.
  always_comb begin
    state_d       = state_q;
    pend_target_d = pend_target_q;
    imem_req      = 1'b0;
    npc           = seq_pc;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;

    if (rst) begin
      state_d       = FETCH;
      pend_target_d = '0;
      npc           = RESET_PC;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
    end else if (!en) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
    end else begin
      case (state_q)
        FETCH: begin
          imem_req = 1'b1;
          if (bus.ex_redirect && bus.imem_ready) begin
            npc         = bus.ex_target;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (bus.ex_redirect) begin
            pend_target_d = bus.ex_target;
            pc_stall      = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            state_d       = DRAIN;
          end else if (bus.load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end else if (!bus.imem_ready) begin
            pc_stall    = 1'b1;
            if_id_flush = 1'b1;
          end
        end
        DRAIN: begin
          imem_req    = 1'b1;
          pc_stall    = 1'b1;
          if_id_flush = 1'b1;
          if (bus.ex_redirect) begin
            pend_target_d = bus.ex_target;
          end
          if (bus.imem_ready) begin
            // A redirect arriving in the same cycle as the returned word
            // is newer than the parked one, so that redirect is taken.
            npc      = bus.ex_redirect ? bus.ex_target : pend_target_q;
            pc_stall = 1'b0;
            state_d  = FETCH;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  // State and parked-target registers. Reset clears them, and a low
  // enable freezes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pend_target_q <= '0;
    end else if (en) begin
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
    end
  end

  // A bubble is any enabled, non-reset cycle in which the PC is held.
  assign count_bubble = en && !rst && pc_stall;

  perf_counter #(
    .WIDTH(32)
  ) u_bubble_cnt (
    .clk    (clk),
    .clear_i(rst),
    .en_i   (count_bubble),
    .count_o(bus.bubble_cnt)
  );

  assign bus.imem_req    = imem_req;
  assign bus.npc         = npc;
  assign bus.pc_stall    = pc_stall;
  assign bus.if_id_stall = if_id_stall;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_flush = id_ex_flush;

endmodule
